// File: rtl/vcbm_pkg.sv
// Shared BCD constants and helpers for the vcbm_bcd_counter slice.
package vcbm_pkg;

  localparam int         DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

  function automatic logic bcd_valid(input logic [DIGIT_W-1:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear, load (invalid codes become 0) and enabled up/down step.
module bcd_digit
  import vcbm_pkg::*;
(
  input  logic               sys_clk,
  input  logic               clr_n,
  input  logic               cin_en,
  input  logic               up,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               sclr,
  output logic [DIGIT_W-1:0] q,
  output logic               tc_up,
  output logic               tc_dn
);

  logic [DIGIT_W-1:0] r_q;
  logic [DIGIT_W-1:0] w_q_next;

  always_comb begin
    w_q_next = r_q;
    if (sclr) begin
      w_q_next = BCD_MIN;
    end else if (ld) begin
      w_q_next = bcd_valid(ld_val) ? ld_val : BCD_MIN;
    end else if (cin_en) begin
      if (up == DIR_UP) begin
        w_q_next = (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
      end else begin
        w_q_next = (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= BCD_MIN;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q     = r_q;
  assign tc_up = (r_q == BCD_MAX);
  assign tc_dn = (r_q == BCD_MIN);

endmodule

// File: rtl/vcbm_bcd_counter.sv
// Multi-decade BCD up/down counter with load, clear, wrap or saturate at terminal count.
module vcbm_bcd_counter
  import vcbm_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b0
) (
  input  logic                      sys_clk,
  input  logic                      clr_n,
  input  logic                      ce,
  input  logic                      up,
  input  logic                      L,
  input  logic                      sclr,
  input  logic [DIGIT_W*DIGITS-1:0] di,
  output logic [DIGIT_W*DIGITS-1:0] Q,
  output logic                      TC,
  output logic                      CEO,
  output logic                      OVF,
  output logic                      LERR
);

  logic [DIGITS-1:0] w_tc_up;
  logic [DIGITS-1:0] w_tc_dn;
  logic [DIGITS-1:0] w_en;
  logic [DIGITS-1:0] w_dig_bad;
  logic              w_tc;
  logic              w_count;
  logic              w_hold;
  logic              r_ovf;
  logic              r_lerr;

  assign w_tc    = (up == DIR_UP) ? (&w_tc_up) : (&w_tc_dn);
  assign w_count = ce & ~sclr & ~L;
  // Saturation freezes the whole chain by killing the lowest enable.
  assign w_hold  = SAT & w_tc;
  assign w_en[0] = ce & ~w_hold;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      if (gi > 0) begin : g_chain
        assign w_en[gi] = w_en[gi-1] &
                          ((up == DIR_UP) ? w_tc_up[gi-1] : w_tc_dn[gi-1]);
      end

      assign w_dig_bad[gi] = ~bcd_valid(di[gi*DIGIT_W +: DIGIT_W]);

      bcd_digit u_digit (
        .sys_clk (sys_clk),
        .clr_n   (clr_n),
        .cin_en  (w_en[gi]),
        .up      (up),
        .ld      (L),
        .ld_val  (di[gi*DIGIT_W +: DIGIT_W]),
        .sclr    (sclr),
        .q       (Q[gi*DIGIT_W +: DIGIT_W]),
        .tc_up   (w_tc_up[gi]),
        .tc_dn   (w_tc_dn[gi])
      );
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ovf  <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_ovf  <= w_count & w_tc;
      r_lerr <= ~sclr & L & (|w_dig_bad);
    end
  end

  assign TC   = w_tc;
  assign CEO  = ce & w_tc;
  assign OVF  = r_ovf;
  assign LERR = r_lerr;

endmodule

// File: tb/tb_vcbm_bcd_counter.sv
// Drives a wrapping and a saturating 4-decade counter with one stimulus stream and checks both against a decimal model.
module tb_vcbm_bcd_counter;

  localparam int MAXV = 9999;

  logic        sys_clk;
  logic        clr_n;
  logic        ce;
  logic        up;
  logic        L;
  logic        sclr;
  logic [15:0] di;
  logic [15:0] q    [2];
  logic        tc   [2];
  logic        ceo  [2];
  logic        ovf  [2];
  logic        lerr [2];

  int m_v    [2];
  bit m_ovf  [2];
  bit m_lerr [2];
  int n_checks = 0;
  int n_pass   = 0;

  vcbm_bcd_counter #(.DIGITS(4), .SAT(1'b0)) u_dut_wrap (
    .sys_clk (sys_clk), .clr_n (clr_n), .ce (ce), .up (up), .L (L), .sclr (sclr),
    .di (di), .Q (q[0]), .TC (tc[0]), .CEO (ceo[0]), .OVF (ovf[0]), .LERR (lerr[0])
  );

  vcbm_bcd_counter #(.DIGITS(4), .SAT(1'b1)) u_dut_sat (
    .sys_clk (sys_clk), .clr_n (clr_n), .ce (ce), .up (up), .L (L), .sclr (sclr),
    .di (di), .Q (q[1]), .TC (tc[1]), .CEO (ceo[1]), .OVF (ovf[1]), .LERR (lerr[1])
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    r = '0;
    t = v;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic load_value(input logic [15:0] d, output int v, output bit bad);
    int pw;
    int dg;
    v   = 0;
    bad = 0;
    pw  = 1;
    for (int k = 0; k < 4; k++) begin
      dg = int'((d >> (4 * k)) & 16'hF);
      if (dg > 9) begin
        bad = 1;
        dg  = 0;
      end
      v  = v + dg * pw;
      pw = pw * 10;
    end
  endtask

  // Index 0 wraps at terminal count, index 1 saturates.
  task automatic model_edge();
    int v;
    bit bad;
    for (int d = 0; d < 2; d++) begin
      m_ovf[d]  = 0;
      m_lerr[d] = 0;
      if (sclr) begin
        m_v[d] = 0;
      end else if (L) begin
        load_value(di, v, bad);
        m_v[d]    = v;
        m_lerr[d] = bad;
      end else if (ce) begin
        if (up) begin
          if (m_v[d] == MAXV) begin
            m_ovf[d] = 1;
            if (d == 0) m_v[d] = 0;
          end else m_v[d] = m_v[d] + 1;
        end else begin
          if (m_v[d] == 0) begin
            m_ovf[d] = 1;
            if (d == 0) m_v[d] = MAXV;
          end else m_v[d] = m_v[d] - 1;
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    logic exp_tc;
    for (int d = 0; d < 2; d++) begin
      exp_tc = up ? (m_v[d] == MAXV) : (m_v[d] == 0);
      chk($sformatf("%s_q%0d", where, d), 32'(q[d]), 32'(to_bcd(m_v[d])));
      chk($sformatf("%s_ovf%0d", where, d), 32'(ovf[d]), 32'(m_ovf[d]));
      chk($sformatf("%s_lerr%0d", where, d), 32'(lerr[d]), 32'(m_lerr[d]));
      chk($sformatf("%s_tc%0d", where, d), 32'(tc[d]), 32'(exp_tc));
      chk($sformatf("%s_ceo%0d", where, d), 32'(ceo[d]), 32'(ce & exp_tc));
    end
  endtask

  // Called one time unit after a rising edge; ends one time unit after the next.
  task automatic step(input logic ce_i, input logic up_i, input logic l_i,
                      input logic sclr_i, input logic [15:0] di_i);
    ce = ce_i; up = up_i; L = l_i; sclr = sclr_i; di = di_i;
    #1;
    check_all("pre");
    @(posedge sys_clk);
    model_edge();
    #1;
    check_all("post");
  endtask

  // Asserts clr_n between edges and releases it before the next edge.
  task automatic do_reset(input logic ce_i, input logic up_i);
    ce = ce_i; up = up_i; L = 1'b0; sclr = 1'b0;
    #2 clr_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_ovf[d] = 0; m_lerr[d] = 0;
    end
    #1;
    check_all("rst");
    #2 clr_n = 1'b1;
  endtask

  initial begin
    int ovf_cnt;
    int ovf_at;
    int kind;
    logic dir;
    logic [15:0] dv;

    clr_n = 1'b0; ce = 1'b0; up = 1'b0; L = 1'b0; sclr = 1'b0; di = '0;
    for (int d = 0; d < 2; d++) begin
      m_v[d] = 0; m_ovf[d] = 0; m_lerr[d] = 0;
    end
    @(posedge sys_clk);
    #1;
    check_all("por");
    do_reset(1'b1, 1'b0);
    $display("scenario reset: q0=%h q1=%h tc0=%b", q[0], q[1], tc[0]);

    ovf_cnt = 0;
    ovf_at  = -1;
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      if (ovf[0]) begin
        ovf_cnt++;
        ovf_at = i;
      end
    end
    chk("wrap_ovf_count", 32'(ovf_cnt), 32'd1);
    chk("wrap_ovf_edge", 32'(ovf_at), 32'd9999);
    chk("wrap_final_q", 32'(q[0]), 32'h0000);
    $display("scenario full count: q0=%h q1=%h ovf_pulses=%0d", q[0], q[1], ovf_cnt);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("borrow_q", 32'(q[0]), 32'h0099);
    $display("scenario borrow: q0=%h ovf0=%b", q[0], ovf[0]);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9998);
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk($sformatf("sat_q_c%0d", i), 32'(q[1]), 32'h9999);
      chk($sformatf("sat_ovf_c%0d", i), 32'(ovf[1]), 32'(i > 1));
      $display("scenario saturate cycle %0d: q1=%h ovf1=%b tc1=%b", i, q[1], ovf[1], tc[1]);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("sat_reverse_q", 32'(q[1]), 32'h9998);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h1A3F);
    chk("bad_load_q", 32'(q[0]), 32'h1030);
    chk("bad_load_lerr", 32'(lerr[0]), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("bad_load_lerr_drop", 32'(lerr[0]), 32'd0);
    $display("scenario invalid load: q0=%h", q[0]);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0457);
    do_reset(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("post_reset_q", 32'(q[0]), 32'h0001);
    $display("scenario async reset: q0=%h", q[0]);

    step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0050);
    step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1A3F);
    chk("sclr_prio_q", 32'(q[0]), 32'h0000);
    chk("sclr_prio_lerr", 32'(lerr[0]), 32'd0);
    $display("scenario sclr priority: q0=%h lerr0=%b ovf0=%b", q[0], lerr[0], ovf[0]);

    dir = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 99) < 2) begin
        do_reset(1'($urandom_range(0, 1)), dir);
      end else begin
        kind = int'($urandom_range(0, 4));
        case (kind)
          0:       dv = 16'($urandom);
          1:       dv = 16'h9999;
          2:       dv = 16'h0000;
          3:       dv = 16'h9998;
          default: dv = 16'h0001;
        endcase
        step(1'($urandom_range(0, 3) != 0), dir, 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 19) == 0), dv);
      end
    end
    $display("scenario random: q0=%h q1=%h", q[0], q[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vcbm_bcd_counter.md
VCBM_BCD_COUNTER -- requirements
Module: vcbm_bcd_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD decades (1..8).
REQ-002 SHALL have parameter SAT, default 0: 0 = wrap at terminal count, 1 = saturate at terminal count.
REQ-003 SHALL have port sys_clk, input, 1, the single system clock, rising-edge active.
REQ-004 SHALL have port clr_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ce, input, 1, count enable.
REQ-006 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port L, input, 1, synchronous parallel load strobe.
REQ-008 SHALL have port sclr, input, 1, synchronous clear.
REQ-009 SHALL have port di, input, 4*DIGITS, load value with digit k in bits [4k+3:4k].
REQ-010 SHALL have port Q, output, 4*DIGITS, registered BCD count with digit 0 as least significant.
REQ-011 SHALL have port TC, output, 1, combinational terminal count.
REQ-012 SHALL have port CEO, output, 1, cascade enable equal to ce & TC.
REQ-013 SHALL have port OVF, output, 1, registered one-cycle over/underflow pulse.
REQ-014 SHALL have port LERR, output, 1, registered one-cycle invalid-load pulse.

Function
REQ-015 SHALL apply actions in priority order: sclr, then L, then ce; when none is active, Q SHALL hold.
REQ-016 SHALL, on sclr, set Q = 0 on the next edge and leave OVF and LERR at 0.
REQ-017 SHALL, on L, load Q from di on the next edge, regardless of ce and up.
REQ-018 SHALL, on a load, replace any digit of di greater than 9 with 0 and assert LERR for one cycle.
REQ-019 SHALL, when ce = 1 and up = 1, increment digit 0 each edge; a digit at 9 SHALL become 0 and carry into the next digit.
REQ-020 SHALL, when ce = 1 and up = 0, decrement digit 0 each edge; a digit at 0 SHALL become 9 and borrow from the next digit.
REQ-021 SHALL update all digits in the same edge, so the full ripple completes in one cycle with a latency of one clock.
REQ-022 SHALL never hold a digit value outside 0..9 in Q.
REQ-023 SHALL drive TC = 1 when up = 1 and every digit is 9, or when up = 0 and every digit is 0; otherwise TC = 0.
REQ-024 SHALL, when SAT = 0 and a count occurs with TC = 1, wrap Q (all-9 to 0 when counting up, 0 to all-9 when counting down) and pulse OVF on the same edge.
REQ-025 SHALL, when SAT = 1 and a count occurs with TC = 1, hold Q and pulse OVF.
REQ-026 SHALL, when SAT = 1, accept counts in the opposite direction normally while Q sits at a terminal value.
REQ-027 SHALL, when up changes, follow the new direction from the next edge, and TC SHALL reflect the new up value combinationally.
REQ-028 SHALL, when L and ce are asserted together, perform the load only, with no count and no OVF.

Reset
REQ-029 SHALL, while clr_n = 0, immediately force Q = 0, OVF = 0 and LERR = 0, independent of sys_clk.
REQ-030 SHALL, on clr_n deassertion, resume operation at the first rising edge of sys_clk.
REQ-031 SHALL let a reset asserted mid-count or mid-load abort that operation, with no partial update surviving.
REQ-032 SHALL hold TC = 1 and CEO = ce during reset when up = 0, because Q = 0.

Structure
REQ-033 SHALL place the constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0 and the digit width constant in shared package vcbm_pkg.
REQ-034 SHALL instantiate one sub-module bcd_digit per decade, with inputs cin_en, up, ld, ld_val, sclr and outputs q, tc_up, tc_dn.
REQ-035 SHALL build the carry/borrow chain in the parent by AND-ing each digit's enable with the lower digits' terminal flags, and generate it for DIGITS instances.
REQ-036 SHALL implement the SAT hold as a global suppression of digit enables in the parent.

Verification
REQ-037 Bench SHALL cover: DIGITS=4, SAT=0, reset, ce=1, up=1 for 10000 cycles -> Q steps 0000..9999 then 0000, with a single OVF pulse on the wrap edge.
REQ-038 Bench SHALL cover: load 0x0100, then up=0, ce=1 for one cycle -> Q = 0x0099 with no OVF.
REQ-039 Bench SHALL cover: SAT=1, load 0x9998, ce=1, up=1 for 3 cycles -> Q = 9999, 9999, 9999, with OVF on cycles 2 and 3 and TC=1 from cycle 1.
REQ-040 Bench SHALL cover: load di = 0x1A3F -> Q = 0x1030 and LERR pulses once.
REQ-041 Bench SHALL cover: Q = 0x0457, ce=1, assert clr_n = 0 between edges -> Q = 0 immediately, and after release with ce=1, up=1, Q = 0x0001 at the first edge.
REQ-042 Bench SHALL cover: sclr=1, L=1, ce=1 together with Q = 0x0050 -> Q = 0x0000, no LERR and no OVF.
